spi_xfer_sched: RTL and testbench

//  Shares one spi_module master among NUM_REQ requesters. Round-robin grant, per-transfer

---
 rtl/spi_ctrl_pkg.sv | 44 ++++
 rtl/spi_rr_arbiter.sv | 33 +++
 rtl/spi_xfer_sched.sv | 172 +++++++++++++++++
 tb/tb_spi_xfer_sched.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared types and helpers for the SPI transfer scheduler.
//   sched_state_e : scheduler FSM states
//   DEF_DATA_W    : default transfer data width
//   DEF_CFG_W     : default config word width
//   rr_pick()     : round-robin search over up to RR_MAX_REQ request lines
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONFIG,
        START,
        WAIT_IRQ,
        DONE
    } sched_state_e;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_CFG_W  = 8;
    localparam int unsigned RR_MAX_REQ = 32;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } rr_pick_t;

    // First set bit of valid[num_req-1:0], searching upward from ptr+1 and wrapping.
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX_REQ-1:0] valid,
        input logic [4:0]            ptr,
        input int unsigned           num_req
    );
        rr_pick_t    r;
        int unsigned k;
        r = '0;
        for (int unsigned i = 1; i <= num_req; i++) begin
            k = (32'(ptr) + i) % num_req;
            if (!r.found && valid[k]) begin
                r.found = 1'b1;
                r.idx   = 5'(k);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick for the SPI transfer scheduler.
//   req_valid : per-requester request lines
//   ptr       : index of the last owner (search starts at ptr+1)
//   found     : at least one request is pending
//   winner    : index of the selected requester (meaningful when found)
// The pointer register itself lives in the scheduler.
module spi_rr_arbiter
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       found,
    output logic [$clog2(NUM_REQ)-1:0] winner
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [RR_MAX_REQ-1:0] valid_ext;
    rr_pick_t              pick;

    always_comb begin
        valid_ext               = '0;
        valid_ext[NUM_REQ-1:0]  = req_valid;
        pick                    = rr_pick(valid_ext, 5'(ptr), NUM_REQ);
        // The range qualifier is always true by construction; it keeps every
        // index bit consumed when ID_W is narrower than the helper's index.
        found                   = pick.found && (32'(pick.idx) < NUM_REQ);
        winner                  = pick.idx[ID_W-1:0];
    end

endmodule

// File: rtl/spi_xfer_sched.sv
// Shares one spi_module master among NUM_REQ requesters.
//   i_sys_clk / i_sys_rst   : clock, asynchronous active-low reset
//   i_req_valid/o_req_ready : per-requester request handshake (ready one-hot)
//   i_req_data / i_req_cfg  : packed per-requester TX byte and config word
//   o_rsp_valid/_data/_err  : one-cycle one-hot completion to the owner
//   o_busy, o_grant_id      : scheduler activity and current/last owner
//   o_spi_*                 : data, config and trans_en toward spi_module
//   i_spi_interrupt/_data   : completion interrupt and RX byte from spi_module
// Flow: IDLE -> CONFIG -> START -> WAIT_IRQ -> DONE -> IDLE, one transfer in flight.
module spi_xfer_sched
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned CFG_W      = DEF_CFG_W,
    parameter int unsigned CFG_SETTLE = 2,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic                       i_sys_clk,
    input  logic                       i_sys_rst,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    output logic [NUM_REQ-1:0]         o_req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]  i_req_data,
    input  logic [NUM_REQ*CFG_W-1:0]   i_req_cfg,
    output logic [NUM_REQ-1:0]         o_rsp_valid,
    output logic [DATA_W-1:0]          o_rsp_data,
    output logic                       o_rsp_err,
    output logic                       o_busy,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
    output logic [DATA_W-1:0]          o_spi_data,
    output logic [CFG_W-1:0]           o_spi_config,
    output logic                       o_spi_trans_en,
    input  logic                       i_spi_interrupt,
    input  logic [DATA_W-1:0]          i_spi_data
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned TO_W  = $clog2(TIMEOUT);
    localparam int unsigned SET_W = (CFG_SETTLE > 1) ? $clog2(CFG_SETTLE) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    sched_state_e     state;
    logic [ID_W-1:0]  ptr;
    logic             arm;
    logic             irq_prev;
    logic             cfg_known;
    logic [CFG_W-1:0] last_cfg;
    logic [SET_W-1:0] settle_cnt;
    logic [TO_W-1:0]  to_cnt;

    logic             found;
    logic [ID_W-1:0]  winner;
    logic             grant;
    logic [DATA_W-1:0] win_data;
    logic [CFG_W-1:0]  win_cfg;
    logic             cfg_change;
    logic             irq_edge;

    spi_rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .req_valid(i_req_valid),
        .ptr      (ptr),
        .found    (found),
        .winner   (winner)
    );

    // arm is a reset-cleared flop so ready stays low while reset is held,
    // even though the state register already reads IDLE.
    assign grant      = (state == IDLE) && arm && !i_spi_interrupt && found;
    assign win_data   = i_req_data[32'(winner) * DATA_W +: DATA_W];
    assign win_cfg    = i_req_cfg[32'(winner) * CFG_W +: CFG_W];
    assign cfg_change = !cfg_known || (win_cfg != last_cfg);
    assign irq_edge   = i_spi_interrupt && !irq_prev;

    always_comb begin
        o_req_ready = '0;
        if (grant) begin
            o_req_ready[winner] = 1'b1;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state          <= IDLE;
            ptr            <= ID_W'(NUM_REQ - 1);
            arm            <= 1'b0;
            irq_prev       <= 1'b0;
            cfg_known      <= 1'b0;
            last_cfg       <= '0;
            settle_cnt     <= '0;
            to_cnt         <= '0;
            o_busy         <= 1'b0;
            o_grant_id     <= '0;
            o_spi_data     <= '0;
            o_spi_config   <= '0;
            o_spi_trans_en <= 1'b0;
            o_rsp_valid    <= '0;
            o_rsp_data     <= '0;
            o_rsp_err      <= 1'b0;
        end else begin
            arm            <= 1'b1;
            irq_prev       <= i_spi_interrupt;
            o_spi_trans_en <= 1'b0;
            o_rsp_valid    <= '0;

            case (state)
                IDLE: begin
                    if (grant) begin
                        o_grant_id   <= winner;
                        o_spi_data   <= win_data;
                        o_spi_config <= win_cfg;
                        settle_cnt   <= cfg_change ? SET_W'(CFG_SETTLE - 1) : '0;
                        o_busy       <= 1'b1;
                        state        <= CONFIG;
                    end
                end

                CONFIG: begin
                    if (settle_cnt == '0) begin
                        last_cfg       <= o_spi_config;
                        cfg_known      <= 1'b1;
                        o_spi_trans_en <= 1'b1;
                        to_cnt         <= '0;
                        state          <= START;
                    end else begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end
                end

                // Counter is zero during START and counts from here, so the
                // timeout completion lands exactly TIMEOUT cycles after START.
                START: begin
                    to_cnt <= to_cnt + TO_W'(1);
                    state  <= WAIT_IRQ;
                end

                WAIT_IRQ: begin
                    if (irq_edge) begin
                        o_rsp_data  <= i_spi_data;
                        o_rsp_err   <= 1'b0;
                        o_rsp_valid <= NUM_REQ'(1) << o_grant_id;
                        state       <= DONE;
                    end else if (to_cnt == TO_LAST) begin
                        o_rsp_data  <= '0;
                        o_rsp_err   <= 1'b1;
                        o_rsp_valid <= NUM_REQ'(1) << o_grant_id;
                        state       <= DONE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                DONE: begin
                    ptr <= o_grant_id;
                    if (o_rsp_err) begin
                        cfg_known <= 1'b0;
                    end
                    o_rsp_data <= '0;
                    o_rsp_err  <= 1'b0;
                    o_busy     <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Self-checking bench for spi_xfer_sched with a behavioural spi_module stand-in.
// The stand-in answers each trans_en with RX = TX ^ 8'h99 after a fixed delay,
// or stays silent to force a timeout.
module tb_spi_xfer_sched;

    localparam int NR        = 4;
    localparam int DW        = 8;
    localparam int CW        = 8;
    localparam int SETTLE    = 2;
    localparam int TMO       = 16;
    localparam int SLAVE_LAT = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     o_req_ready;
    logic [NR*DW-1:0]  req_data = '0;
    logic [NR*CW-1:0]  req_cfg = '0;
    logic [NR-1:0]     o_rsp_valid;
    logic [DW-1:0]     o_rsp_data;
    logic              o_rsp_err;
    logic              o_busy;
    logic [1:0]        o_grant_id;
    logic [DW-1:0]     o_spi_data;
    logic [CW-1:0]     o_spi_config;
    logic              o_spi_trans_en;
    logic              spi_irq = 1'b0;
    logic [DW-1:0]     spi_rx = '0;

    int          vec = 0;
    int          miscmp = 0;
    int unsigned cyc = 0;

    typedef struct {
        int         id;
        logic [7:0] data;
        logic       err;
    } exp_t;
    exp_t sb[$];

    bit         slave_silent = 1'b0;
    int         slave_hold = 2;
    int         model_ptr = NR - 1;
    bit         model_known = 1'b0;
    logic [7:0] model_last = '0;

    spi_xfer_sched #(
        .NUM_REQ   (NR),
        .DATA_W    (DW),
        .CFG_W     (CW),
        .CFG_SETTLE(SETTLE),
        .TIMEOUT   (TMO)
    ) dut (
        .i_sys_clk      (clk),
        .i_sys_rst      (rst_n),
        .i_req_valid    (req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_data     (req_data),
        .i_req_cfg      (req_cfg),
        .o_rsp_valid    (o_rsp_valid),
        .o_rsp_data     (o_rsp_data),
        .o_rsp_err      (o_rsp_err),
        .o_busy         (o_busy),
        .o_grant_id     (o_grant_id),
        .o_spi_data     (o_spi_data),
        .o_spi_config   (o_spi_config),
        .o_spi_trans_en (o_spi_trans_en),
        .i_spi_interrupt(spi_irq),
        .i_spi_data     (spi_rx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // spi_module stand-in
    initial begin
        logic [7:0] tx;
        forever begin
            @(negedge clk);
            if (rst_n && o_spi_trans_en && !slave_silent) begin
                tx = o_spi_data;
                repeat (SLAVE_LAT) @(posedge clk);
                #1;
                spi_rx  = tx ^ 8'h99;
                spi_irq = 1'b1;
                repeat (slave_hold) @(posedge clk);
                #1;
                spi_irq = 1'b0;
            end
        end
    end

    // Scoreboard: push on handshake, pop on completion; ready qualification.
    initial begin
        exp_t          e;
        logic [NR-1:0] oh;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (o_req_ready != '0) begin
                    vec++;
                    if (spi_irq || ((o_req_ready & ~req_valid) != '0) || ($countones(o_req_ready) != 1)) begin
                        miscmp++;
                        $display("FAIL ready_qual: ready=%b valid=%b irq=%b, required one-hot, within valid, irq low",
                                 o_req_ready, req_valid, spi_irq);
                    end
                end
                if ((o_req_ready & req_valid) != '0) begin
                    e.id = 0;
                    for (int k = 0; k < NR; k++) if (o_req_ready[k]) e.id = k;
                    e.err  = slave_silent;
                    e.data = slave_silent ? 8'h00 : (req_data[e.id*DW +: DW] ^ 8'h99);
                    sb.push_back(e);
                end
                if (o_rsp_valid != '0) begin
                    vec++;
                    if (sb.size() == 0) begin
                        miscmp++;
                        $display("FAIL rsp_unexpected: rsp_valid=%b, required no response", o_rsp_valid);
                    end else begin
                        e  = sb.pop_front();
                        oh = 4'(1) << e.id;
                        if (o_rsp_valid !== oh || o_rsp_data !== e.data || o_rsp_err !== e.err) begin
                            miscmp++;
                            $display("FAIL rsp_content: got valid=%b data=%h err=%b, required valid=%b data=%h err=%b",
                                     o_rsp_valid, o_rsp_data, o_rsp_err, oh, e.data, e.err);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One complete transfer for requester id; returns CONFIG length and RX byte.
    task automatic do_xfer(input int id, input logic [7:0] d, input logic [7:0] c,
                           output int cfg_cyc, output logic [7:0] rsp_d);
        int exp_cfg, exp_lat, lat, extra_tr;
        int unsigned tr_cyc;
        bit got;
        exp_cfg = (!model_known || c != model_last) ? SETTLE : 1;
        exp_lat = slave_silent ? TMO : SLAVE_LAT + 1;
        cfg_cyc = 0;
        rsp_d   = '0;
        @(posedge clk); #1;
        req_data[id*DW +: DW] = d;
        req_cfg[id*CW +: CW]  = c;
        req_valid[id]         = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (o_req_ready[id]) got = 1'b1;
        end
        vec++;
        if (!got) begin
            miscmp++;
            $display("FAIL xfer_grant: requester %0d got no ready within 60 cycles, required ready", id);
            req_valid[id] = 1'b0;
            return;
        end
        model_ptr = id;
        // Scramble the source after the handshake: the DUT must hold its latched copy.
        @(posedge clk); #1;
        req_valid[id]         = 1'b0;
        req_data[id*DW +: DW] = ~d;
        req_cfg[id*CW +: CW]  = ~c;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (o_spi_trans_en) got = 1'b1;
            else cfg_cyc++;
        end
        tr_cyc = cyc;
        vec++;
        if (!got || cfg_cyc != exp_cfg) begin
            miscmp++;
            $display("FAIL cfg_settle: config cycles %0d (trans_en seen %0b), required %0d", cfg_cyc, got, exp_cfg);
        end
        vec++;
        if (o_spi_data !== d || o_spi_config !== c) begin
            miscmp++;
            $display("FAIL spi_drive: data=%h cfg=%h, required data=%h cfg=%h", o_spi_data, o_spi_config, d, c);
        end
        model_last  = c;
        model_known = !slave_silent;
        got = 1'b0;
        extra_tr = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (o_spi_trans_en) extra_tr++;
            if (o_rsp_valid[id]) begin
                got   = 1'b1;
                rsp_d = o_rsp_data;
            end
        end
        lat = int'(cyc - tr_cyc);
        vec++;
        if (!got || lat != exp_lat || extra_tr != 0) begin
            miscmp++;
            $display("FAIL rsp_timing: rsp seen %0b latency %0d extra trans_en %0d, required latency %0d no extra",
                     got, lat, extra_tr, exp_lat);
        end
        repeat (slave_hold + 1) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        req_data  = 32'hDEADBEEF;
        req_cfg   = 32'h12345678;
        repeat (3) @(negedge clk);
        vec++; if (o_req_ready !== '0)    begin miscmp++; $display("FAIL reset_ready: %b required 0", o_req_ready); end
        vec++; if (o_rsp_valid !== '0)    begin miscmp++; $display("FAIL reset_rsp_valid: %b required 0", o_rsp_valid); end
        vec++; if (o_rsp_data !== '0)     begin miscmp++; $display("FAIL reset_rsp_data: %h required 0", o_rsp_data); end
        vec++; if (o_rsp_err !== 1'b0)    begin miscmp++; $display("FAIL reset_rsp_err: %b required 0", o_rsp_err); end
        vec++; if (o_busy !== 1'b0)       begin miscmp++; $display("FAIL reset_busy: %b required 0", o_busy); end
        vec++; if (o_grant_id !== '0)     begin miscmp++; $display("FAIL reset_grant_id: %0d required 0", o_grant_id); end
        vec++; if (o_spi_data !== '0)     begin miscmp++; $display("FAIL reset_spi_data: %h required 0", o_spi_data); end
        vec++; if (o_spi_config !== '0)   begin miscmp++; $display("FAIL reset_spi_config: %h required 0", o_spi_config); end
        vec++; if (o_spi_trans_en !== 1'b0) begin miscmp++; $display("FAIL reset_trans_en: %b required 0", o_spi_trans_en); end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        rst_n       = 1'b1;
        model_ptr   = NR - 1;
        model_known = 1'b0;
    endtask

    task automatic test_single();
        int cc;
        logic [7:0] rd;
        slave_silent = 1'b0;
        do_xfer(1, 8'hA5, 8'h03, cc, rd);
        vec++;
        if (rd !== 8'h3C) begin miscmp++; $display("FAIL single_rx: %h required 3c", rd); end
        vec++;
        if (cc != SETTLE) begin miscmp++; $display("FAIL single_settle: %0d required %0d", cc, SETTLE); end
    endtask

    task automatic test_round_robin();
        int grants, w, exp_w;
        bit drained;
        slave_hold = 4;
        @(posedge clk); #1;
        for (int k = 0; k < NR; k++) begin
            req_data[k*DW +: DW] = 8'(8'h10 * (k + 1) + k);
            req_cfg[k*CW +: CW]  = 8'h03;
        end
        req_valid = '1;
        grants = 0;
        for (int i = 0; i < 400 && grants < 5; i++) begin
            @(negedge clk);
            if ((o_req_ready & req_valid) != '0) begin
                w = 0;
                for (int k = 0; k < NR; k++) if (o_req_ready[k]) w = k;
                exp_w = (model_ptr + 1) % NR;
                vec++;
                if (w != exp_w) begin
                    miscmp++;
                    $display("FAIL rr_order: grant %0d went to %0d, required %0d", grants, w, exp_w);
                end
                model_ptr = exp_w;
                grants++;
            end
        end
        vec++;
        if (grants != 5) begin miscmp++; $display("FAIL rr_count: %0d grants, required 5", grants); end
        @(posedge clk); #1;
        req_valid = '0;
        drained = 1'b0;
        for (int i = 0; i < 100 && !drained; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !o_busy) drained = 1'b1;
        end
        vec++;
        if (!drained) begin miscmp++; $display("FAIL rr_drain: %0d responses outstanding, required 0", sb.size()); end
        repeat (6) @(negedge clk);
        slave_hold  = 2;
        model_known = 1'b1;
        model_last  = 8'h03;
    endtask

    task automatic test_cfg_reuse();
        int cc;
        logic [7:0] rd;
        do_xfer(0, 8'h11, 8'h03, cc, rd);
        do_xfer(0, 8'h22, 8'h03, cc, rd);
        vec++;
        if (cc != 1) begin miscmp++; $display("FAIL cfg_same: %0d config cycles, required 1", cc); end
        do_xfer(0, 8'h33, 8'h01, cc, rd);
        vec++;
        if (cc != SETTLE) begin miscmp++; $display("FAIL cfg_change: %0d config cycles, required %0d", cc, SETTLE); end
    endtask

    task automatic test_timeout();
        int cc;
        logic [7:0] rd;
        slave_silent = 1'b1;
        do_xfer(2, 8'h44, 8'h01, cc, rd);
        slave_silent = 1'b0;
        do_xfer(2, 8'h55, 8'h01, cc, rd);
        vec++;
        if (cc != SETTLE) begin miscmp++; $display("FAIL timeout_resettle: %0d config cycles, required %0d", cc, SETTLE); end
    endtask

    task automatic test_mid_reset();
        bit got;
        slave_silent = 1'b1;
        @(posedge clk); #1;
        req_data[2*DW +: DW] = 8'h66;
        req_cfg[2*CW +: CW]  = 8'h07;
        req_valid[2]         = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (o_req_ready[2]) got = 1'b1;
        end
        @(posedge clk); #1;
        req_valid = '0;
        for (int i = 0; i < 20 && !got; i++) @(negedge clk);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (o_spi_trans_en) got = 1'b1;
        end
        vec++;
        if (!got) begin miscmp++; $display("FAIL midrst_start: no trans_en seen, required one"); end
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vec++;
        if (o_spi_trans_en !== 1'b0 || o_busy !== 1'b0 || o_rsp_valid !== '0) begin
            miscmp++;
            $display("FAIL midrst_async: trans_en=%b busy=%b rsp_valid=%b, required all 0",
                     o_spi_trans_en, o_busy, o_rsp_valid);
        end
        sb.delete();
        got = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (o_rsp_valid != '0 || o_busy) got = 1'b1;
        end
        vec++;
        if (got) begin miscmp++; $display("FAIL midrst_hold: activity during reset, required none"); end
        rst_n        = 1'b1;
        model_ptr    = NR - 1;
        model_known  = 1'b0;
        slave_silent = 1'b0;
        @(posedge clk); #1;
        req_data  = 32'h77_00_88_99;
        req_cfg   = 32'h03_03_03_05;
        req_valid = 4'b1101;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (o_req_ready != '0) got = 1'b1;
        end
        vec++;
        if (o_req_ready !== 4'b0001) begin
            miscmp++;
            $display("FAIL midrst_first: ready=%b, required 0001", o_req_ready);
        end
        @(posedge clk); #1;
        req_valid = '0;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !o_busy) got = 1'b1;
        end
        vec++;
        if (!got) begin miscmp++; $display("FAIL midrst_drain: %0d responses outstanding, required 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_cfg_reuse();
        test_timeout();
        test_mid_reset();
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule
